// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Types and constants shared by the UART TX and RX stream
//               blocks: the FSM state encoding, the data width, the baud
//               counter width and the default baud divider.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int BAUD_CNT_W           = 16;
  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled
//               and wraps to 0; o_tick marks the last cycle of each period.
//               Holds its value while disabled, so it never free-runs.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               i_clear - synchronous clear to 0 (priority over enable)
//               i_en    - count enable
//               o_tick  - high on the final cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [BAUD_CNT_W-1:0] CNT_MAX = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] r_cnt;
  logic                  w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);
  assign o_tick   = i_en && w_at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_at_max) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + BAUD_CNT_W'(1);
      end
    end
  end

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/stream_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : stream_uart_tx
// Description : Consumes 32-bit stb/ack stream words and transmits bits [7:0]
//               as an asynchronous serial frame (start, 8 data bits LSB
//               first, optional even parity, 1 or 2 stop bits).
//               Optional feature macro: UART_TX_PARITY_EN (8E1/8E2 framing
//               when defined, 8N1/8N2 otherwise).
// Ports       : clk     - system clock, rising edge
//               rst     - asynchronous active-low reset
//               in_data - stream word, only [7:0] is transmitted
//               in_stb  - producer has a valid word
//               in_ack  - registered ready; transfer on in_stb && in_ack
//               tx      - serial line, idle high, driven from a flop
//               busy    - high from acceptance until the last stop bit ends
// Revision    : 1.0 - initial release
// ============================================================================
module stream_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int IDLE_STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_stb,
  output logic        in_ack,
  output logic        tx,
  output logic        busy
);

  localparam int                   BIT_IDX_W = $clog2(DATA_BITS);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP = BIT_IDX_W'(IDLE_STOP_BITS - 1);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 r_in_ack;
  logic                 r_tx;
  logic                 r_busy;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_accept;
  logic w_tick;
  logic w_baud_en;
  // Upper stream bits are deliberately not transmitted.
  logic w_unused;

  assign w_unused  = &{1'b0, in_data[31:DATA_BITS]};
  assign w_accept  = (r_state == ST_IDLE) && r_in_ack && in_stb;
  assign w_baud_en = (r_state != ST_IDLE);

  assign in_ack = r_in_ack;
  assign tx     = r_tx;
  assign busy   = r_busy;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (w_accept),
    .i_en    (w_baud_en),
    .o_tick  (w_tick)
  );

  // tx is loaded from the current state, so the line lags the state by one
  // cycle: the start bit appears on the edge after the accepting edge and
  // the last stop bit runs one cycle past the return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_in_ack  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shift   <= in_data[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^in_data[DATA_BITS-1:0];
`endif
            r_in_ack  <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_idx <= '0;
            r_state   <= ST_START;
          end else begin
            r_in_ack <= 1'b1;
          end
        end

        ST_START: begin
          r_tx <= 1'b0;
          if (w_tick) begin
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          r_tx <= r_shift[0];
          if (w_tick) begin
            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == LAST_DATA) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          r_tx <= r_parity;
          if (w_tick) begin
            r_bit_idx <= '0;
            r_state   <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          r_tx <= 1'b1;
          // r_bit_idx counts completed stop bits.
          if (w_tick) begin
            if (r_bit_idx == LAST_STOP) begin
              r_bit_idx <= '0;
              r_busy    <= 1'b0;
              r_in_ack  <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
            end
          end
        end

        default: begin
          r_tx     <= 1'b1;
          r_busy   <= 1'b0;
          r_in_ack <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : stream_uart_tx
`default_nettype wire

// File: tb/tb_stream_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_uart_tx
// Description : Directed self-checking bench for stream_uart_tx with
//               CLKS_PER_BIT=4 and one stop bit. Honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_stb;
  logic        in_ack;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_uart_tx #(
    .CLKS_PER_BIT   (CPB),
    .IDLE_STOP_BITS (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_stb  (in_stb),
    .in_ack  (in_ack),
    .tx      (tx),
    .busy    (busy)
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Expected line level for bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge with in_ack high; presents w for one edge and then
  // checks the acceptance cycle. hold keeps in_stb asserted afterwards.
  task automatic accept(input logic [31:0] w, input logic hold);
    chk("ack_before_accept", 0, in_ack, 1'b1);
    in_stb  = 1'b1;
    in_data = w;
    @(negedge clk);
    chk("ack_drop_on_accept", 0, in_ack, 1'b0);
    chk("busy_on_accept", 0, busy, 1'b1);
    chk("tx_idle_on_accept", 0, tx, 1'b1);
    in_stb = hold;
  endtask

  // Starts at the negedge following the accepting edge; walks the whole
  // frame cycle by cycle while scrambling in_data, which must be ignored.
  task automatic run_frame(input string tag, input logic [7:0] b);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      chk(tag, k, tx, frame_bit(b, (k - 1) / CPB));
      chk("busy", k, busy, (k < FRAME));
      chk("ack_in_frame", k, in_ack, (k == FRAME));
      if (k < FRAME) in_data = $urandom;
    end
  endtask

  initial begin
    rst     = 1'b0;
    in_stb  = 1'b0;
    in_data = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx", 0, tx, 1'b1);
    chk("rst_busy", 0, busy, 1'b0);
    chk("rst_ack", 0, in_ack, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ack_first_edge", 0, in_ack, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("ack_held", i, in_ack, 1'b1);
      chk("tx_idle", i, tx, 1'b1);
      chk("busy_idle", i, busy, 1'b0);
    end

    // 0x55: alternating line
    accept(32'h0000_0055, 1'b0);
    run_frame("f55", 8'h55);
    @(negedge clk);
    chk("post55_ack", 0, in_ack, 1'b1);
    chk("post55_tx", 0, tx, 1'b1);

    // 0xDEADBEA5: only 0xA5 reaches the line
    accept(32'hDEAD_BEA5, 1'b0);
    run_frame("fA5", 8'hA5);

    // Back-to-back 0x41 / 0x42 with in_stb held
    @(negedge clk);
    accept(32'h0000_0041, 1'b1);
    run_frame("f41", 8'h41);
    in_data = 32'h0000_0042;
    @(negedge clk);
    chk("b2b_accept41_ack", 0, in_ack, 1'b0);
    chk("b2b_accept41_busy", 0, busy, 1'b1);
    chk("b2b_idle_gap_tx", 0, tx, 1'b1);
    in_stb = 1'b0;
    run_frame("f42", 8'h42);
    @(negedge clk);
    chk("b2b_no_dup_ack", 0, in_ack, 1'b1);
    chk("b2b_no_dup_busy", 0, busy, 1'b0);

    // Asynchronous reset in the middle of a 0xFF frame
    accept(32'h0000_00FF, 1'b0);
    repeat (12) @(negedge clk);
    chk("ff_busy_before_rst", 0, busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", 0, tx, 1'b1);
    chk("async_rst_busy", 0, busy, 1'b0);
    chk("async_rst_ack", 0, in_ack, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_release_ack", 0, in_ack, 1'b0);
    @(negedge clk);
    chk("rst_release_ack_rise", 0, in_ack, 1'b1);
    chk("rst_release_tx", 0, tx, 1'b1);
    accept(32'h0000_000F, 1'b0);
    run_frame("f0F", 8'h0F);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0
    @(negedge clk);
    accept(32'h0000_0007, 1'b0);
    run_frame("p07", 8'h07);
    @(negedge clk);
    accept(32'h0000_0003, 1'b0);
    run_frame("p03", 8'h03);
`endif

    repeat (3) @(negedge clk);
    chk("final_idle_tx", 0, tx, 1'b1);
    chk("final_idle_ack", 0, in_ack, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_uart_tx
`default_nettype wire
